// File: rtl/mesh_router.sv
// mesh_router: 5-port wormhole router with per-input FIFOs, XY routing and per-output round-robin locking
module mesh_router #(
  parameter int FLIT_W = 34,
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5*FLIT_W-1:0] in_flit,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_ready,
  output logic [5*FLIT_W-1:0] out_flit,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_ready,
  output logic [4:0]          err_orphan
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0, S_ACTIVE = 1'b1;
  localparam logic [X_W-1:0] MX = X_W'(MY_X);
  localparam logic [Y_W-1:0] MY = Y_W'(MY_Y);
  logic [FLIT_W-1:0] mem [5][DEPTH];
  logic [FLIT_W-1:0] hd [5];
  logic [AW-1:0] wp [5], rp [5];
  logic [AW:0] cnt [5];
  logic [0:0] st [5];
  logic [2:0] dir [5], rt [5], ptr [5], src [5], fo [5];
  logic [X_W-1:0] dx [5];
  logic [Y_W-1:0] dy [5];
  logic [4:0] ne, push, pop, orph, req, lk, ld, gnt, fwd, can;
  assign can = ~out_valid | out_ready;
  assign push = in_valid & in_ready;
  assign pop = fwd | orph;
  // FIFO head decode: XY route, head request, orphan detection, ready
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      hd[p] = mem[p][rp[p]];
      dx[p] = hd[p][X_W-1:0];
      dy[p] = hd[p][X_W+Y_W-1:X_W];
      rt[p] = dx[p] > MX ? 3'd2 : dx[p] < MX ? 3'd3 : dy[p] > MY ? 3'd0 : dy[p] < MY ? 3'd1 : 3'd4;
      ne[p] = cnt[p] != '0;
      req[p] = st[p] == S_IDLE && ne[p] && hd[p][FLIT_W-2];
      orph[p] = st[p] == S_IDLE && ne[p] && !hd[p][FLIT_W-2];
      in_ready[p] = !rst && cnt[p] != (AW+1)'(DEPTH);
    end
  end
  // Per-output owner lookup, round-robin grant and load select
  always_comb begin
    fwd = '0;
    lk = '0;
    ld = '0;
    gnt = '0;
    for (int p = 0; p < 5; p++) fo[p] = 3'd0;
    for (int o = 0; o < 5; o++) begin
      src[o] = 3'd0;
      for (int p = 0; p < 5; p++)
        if (st[p] == S_ACTIVE && dir[p] == 3'(o)) begin
          lk[o] = 1'b1;
          src[o] = 3'(p);
        end
      if (lk[o]) ld[o] = can[o] && ne[src[o]];
      else
        for (int k = 4; k >= 0; k--)
          if (req[(int'(ptr[o]) + k) % 5] && rt[(int'(ptr[o]) + k) % 5] == 3'(o)) begin
            gnt[o] = can[o];
            src[o] = 3'((int'(ptr[o]) + k) % 5);
          end
      ld[o] = ld[o] | gnt[o];
      if (ld[o]) begin
        fwd[src[o]] = 1'b1;
        fo[src[o]] = 3'(o);
      end
    end
  end
  // FIFO storage writes; contents need no reset since counters gate reads
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++)
      if (push[p]) mem[p][wp[p]] <= in_flit[p*FLIT_W +: FLIT_W];
  end
  // FIFO pointers, input lock state, arbiter pointers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_flit <= '0;
      err_orphan <= '0;
      for (int p = 0; p < 5; p++) begin
        wp[p] <= '0;
        rp[p] <= '0;
        cnt[p] <= '0;
        st[p] <= S_IDLE;
        dir[p] <= 3'd0;
        ptr[p] <= 3'd0;
      end
    end else begin
      err_orphan <= orph;
      for (int p = 0; p < 5; p++) begin
        if (push[p]) wp[p] <= wp[p] + 1'b1;
        if (pop[p]) rp[p] <= rp[p] + 1'b1;
        cnt[p] <= cnt[p] + {{AW{1'b0}}, push[p]} - {{AW{1'b0}}, pop[p]};
        if (fwd[p]) begin
          st[p] <= hd[p][FLIT_W-1:FLIT_W-2] == 2'b01 ? S_ACTIVE : hd[p][FLIT_W-1:FLIT_W-2] == 2'b10 ? S_IDLE : st[p];
          dir[p] <= fo[p];
        end
      end
      for (int o = 0; o < 5; o++) begin
        if (ld[o]) begin
          out_flit[o*FLIT_W +: FLIT_W] <= hd[src[o]];
          out_valid[o] <= 1'b1;
        end else if (out_ready[o]) out_valid[o] <= 1'b0;
        if (gnt[o]) ptr[o] <= src[o] == 3'd4 ? 3'd0 : src[o] + 3'd1;
      end
    end
  end
endmodule
